// File: rtl/apb_requester_fifo.sv
// Queued APB4 requester: local commands enter a command FIFO, are issued as
// back-to-back APB transfers, and completions return through a response FIFO.
// Launch is gated by response credit, so every completion always has a slot.
module apb_requester_fifo #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [2:0]                    PPROT,
  output logic                          PNSE,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [DATA_WIDTH/8-1:0]       PSTRB,
  input  logic                          PREADY,
  input  logic                          PSLVERR,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]         CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]         CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0]       CMD_WSTB,
  input  logic [2:0]                    CMD_PROT,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [DATA_WIDTH-1:0]         RSP_RDATA,
  output logic                          RSP_SLVERR,
  output logic                          RSP_TIMEOUT,
  output logic [$clog2(CMD_DEPTH):0]    CMD_LEVEL
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CPW    = $clog2(CMD_DEPTH);
  localparam int unsigned RPW    = $clog2(RSP_DEPTH);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CPW:0]  CMD_FULL = (CPW + 1)'(CMD_DEPTH);
  localparam logic [RPW:0]  RSP_FULL = (RPW + 1)'(RSP_DEPTH);
  localparam logic [RPW:0]  RSP_LAST = (RPW + 1)'(RSP_DEPTH - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstb;
    logic [2:0]            prot;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  // Storage and state
  cmd_t              cmd_mem_q [CMD_DEPTH];
  rsp_t              rsp_mem_q [RSP_DEPTH];
  logic [CPW-1:0]    cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic [CPW:0]      cmd_cnt_q, cmd_cnt_d;
  logic [RPW-1:0]    rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [RPW:0]      rsp_cnt_q, rsp_cnt_d;
  state_e            state_q, state_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;

  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;

  cmd_t cmd_in, cmd_head;
  rsp_t rsp_in, rsp_head;
  logic cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic cmd_nonempty, credit_idle, credit_busy, timeout_hit;

  // Handshakes and FIFO status
  always_comb begin
    cmd_in       = '{write: CMD_WRITE, addr: CMD_ADDR, wdata: CMD_WDATA,
                     wstb: CMD_WSTB, prot: CMD_PROT};
    cmd_head     = cmd_mem_q[cmd_rptr_q];
    rsp_head     = rsp_mem_q[rsp_rptr_q];
    CMD_READY    = (cmd_cnt_q != CMD_FULL);
    RSP_VALID    = (rsp_cnt_q != '0);
    cmd_push     = CMD_VALID & CMD_READY;
    rsp_pop      = RSP_VALID & RSP_READY;
    cmd_nonempty = (cmd_cnt_q != '0);
    // IDLE has nothing in flight; at completion the slot being written is counted
    credit_idle  = (rsp_cnt_q < RSP_FULL);
    credit_busy  = (rsp_cnt_q < RSP_LAST);
    timeout_hit  = TO_EN && (state_q == ST_ACCESS) && !PREADY && (to_cnt_q == TO_MAX);
  end

  // APB sequencing: next state, launch, completion and timeout
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_in    = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_nonempty && credit_idle) cmd_pop = 1'b1;
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        to_cnt_d  = '0;
      end
      ST_ACCESS: begin
        if (psel_q && penable_q && PREADY) begin
          rsp_push       = 1'b1;
          rsp_in.rdata   = pwrite_q ? '0 : PRDATA;
          rsp_in.slverr  = PSLVERR;
          if (cmd_nonempty && credit_busy) begin
            cmd_pop = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (timeout_hit) begin
          rsp_push       = 1'b1;
          rsp_in.slverr  = 1'b1;
          rsp_in.timeout = 1'b1;
          state_d        = ST_IDLE;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    if (cmd_pop) begin
      state_d   = ST_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = cmd_head.write;
      paddr_d   = cmd_head.addr;
      pwdata_d  = cmd_head.wdata;
      pstrb_d   = cmd_head.write ? cmd_head.wstb : '0;
      pprot_d   = cmd_head.prot;
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    cmd_wptr_d = cmd_push ? cmd_wptr_q + CPW'(1) : cmd_wptr_q;
    cmd_rptr_d = cmd_pop  ? cmd_rptr_q + CPW'(1) : cmd_rptr_q;
    rsp_wptr_d = rsp_push ? rsp_wptr_q + RPW'(1) : rsp_wptr_q;
    rsp_rptr_d = rsp_pop  ? rsp_rptr_q + RPW'(1) : rsp_rptr_q;
    cmd_cnt_d  = cmd_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_d = cmd_cnt_q + (CPW + 1)'(1);
      2'b01:   cmd_cnt_d = cmd_cnt_q - (CPW + 1)'(1);
      default: cmd_cnt_d = cmd_cnt_q;
    endcase
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + (RPW + 1)'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - (RPW + 1)'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  // Control and APB output registers with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= '0;
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_cnt_q  <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      cmd_wptr_q <= cmd_wptr_d;
      cmd_rptr_q <= cmd_rptr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rsp_wptr_q <= rsp_wptr_d;
      rsp_rptr_q <= rsp_rptr_d;
      rsp_cnt_q  <= rsp_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      pprot_q    <= pprot_d;
    end
  end

  // FIFO storage; contents are don't-care until the matching pointer is valid
  always_ff @(posedge PCLK) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q] <= cmd_in;
    if (rsp_push) rsp_mem_q[rsp_wptr_q] <= rsp_in;
  end

  // Output mapping; response data is masked while the FIFO is empty
  always_comb begin
    PSEL        = psel_q;
    PENABLE     = penable_q;
    PWRITE      = pwrite_q;
    PADDR       = paddr_q;
    PWDATA      = pwdata_q;
    PSTRB       = pstrb_q;
    PPROT       = pprot_q;
    PNSE        = 1'b0;
    CMD_LEVEL   = cmd_cnt_q;
    RSP_RDATA   = RSP_VALID ? rsp_head.rdata   : '0;
    RSP_SLVERR  = RSP_VALID ? rsp_head.slverr  : 1'b0;
    RSP_TIMEOUT = RSP_VALID ? rsp_head.timeout : 1'b0;
  end

endmodule

// File: tb/tb_apb_requester_fifo.sv
// Bench for apb_requester_fifo: directed scenarios plus randomized traffic
// against a completer model and an in-order expected-response queue.
module tb_apb_requester_fifo;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        to;
  } rsp_t;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic [31:0] PADDR, PWDATA, PRDATA = '0;
  logic [2:0]  PPROT;
  logic        PNSE, PSEL, PENABLE, PWRITE;
  logic [3:0]  PSTRB;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
  logic [31:0] CMD_ADDR = '0, CMD_WDATA = '0;
  logic [3:0]  CMD_WSTB = '0;
  logic [2:0]  CMD_PROT = '0;
  logic        RSP_VALID, RSP_READY = 1'b1, RSP_SLVERR, RSP_TIMEOUT;
  logic [31:0] RSP_RDATA;
  logic [2:0]  CMD_LEVEL;

  apb_requester_fifo #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTB(CMD_WSTB),
    .CMD_PROT(CMD_PROT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_SLVERR(RSP_SLVERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .CMD_LEVEL(CMD_LEVEL)
  );

  always #5 PCLK = ~PCLK;

  int   n_checks = 0, n_pass = 0;
  int   n_complete = 0, stab_viol = 0;
  rsp_t got_q[$];
  rsp_t exp_q[$];

  // Completer configuration
  int   cfg_wait = 0;
  bit   cfg_err = 1'b0, cfg_stuck = 1'b0, cfg_random = 1'b0, rand_rsp = 1'b0;
  int   acc_cnt = 0;
  logic [72:0] setup_snap;

  // Reference response for a command under the completer's rules
  function automatic rsp_t model_rsp(input bit w, input logic [31:0] a, input bit err);
    rsp_t r;
    r.rdata  = w ? 32'h0 : a + 32'h1;
    r.slverr = err;
    r.to     = 1'b0;
    return r;
  endfunction

  // Completer: drives PREADY/PSLVERR/PRDATA shortly after each rising edge
  always @(posedge PCLK) begin
    int w;
    bit e;
    #2;
    if (PSEL && PENABLE) begin
      w = cfg_random ? int'(PADDR[5:4]) : cfg_wait;
      e = cfg_random ? PADDR[2] : cfg_err;
      PREADY  = !cfg_stuck && (acc_cnt >= w);
      PSLVERR = PREADY ? e : 1'b0;
      PRDATA  = PADDR + 32'h1;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
    end
  end

  // Random response back-pressure
  always @(posedge PCLK) begin
    if (rand_rsp) begin
      #1;
      RSP_READY = 1'($urandom_range(0, 1));
    end
  end

  // Observers: accepted responses, completions, address-phase stability
  always @(negedge PCLK) begin
    if (RSP_VALID && RSP_READY) got_q.push_back({RSP_RDATA, RSP_SLVERR, RSP_TIMEOUT});
    if (PSEL && PENABLE && PREADY) n_complete++;
    if (PSEL && !PENABLE) setup_snap = {PADDR, PWRITE, PWDATA, PSTRB};
    if (PSEL && PENABLE && (setup_snap !== {PADDR, PWRITE, PWDATA, PSTRB})) stab_viol++;
  end

  task automatic push_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, output bit ok);
    int n = 0;
    @(negedge PCLK);
    CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d;
    CMD_WSTB = s; CMD_PROT = p;
    while (!CMD_READY && n < 500) begin @(negedge PCLK); n++; end
    ok = CMD_READY;
    if (ok) @(posedge PCLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_q.size() < n && c < budget) begin @(negedge PCLK); c++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PNSE, PPROT, PSTRB} !== 11'h0)
      $display("FAIL reset_ctrl got %h want 0", {PSEL, PENABLE, PWRITE, PNSE, PPROT, PSTRB});
    else n_pass++;
    n_checks++;
    if ({PADDR, PWDATA} !== 64'h0) $display("FAIL reset_addr_data got %h want 0", {PADDR, PWDATA});
    else n_pass++;
    n_checks++;
    if ({RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, RSP_RDATA} !== 35'h0)
      $display("FAIL reset_rsp got %h want 0", {RSP_VALID, RSP_SLVERR, RSP_TIMEOUT, RSP_RDATA});
    else n_pass++;
    n_checks++;
    if (CMD_LEVEL !== 3'd0) $display("FAIL reset_level got %0d want 0", CMD_LEVEL);
    else n_pass++;
    n_checks++;
    if (CMD_READY !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", CMD_READY);
    else n_pass++;
  endtask

  task automatic test_single_write;
    bit ok;
    got_q.delete();
    RSP_READY = 1'b1; cfg_wait = 0; cfg_err = 1'b0;
    push_cmd(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'd2, ok);
    @(negedge PCLK);
    n_checks++;
    if (PSEL !== 1'b0) $display("FAIL sw_psel_n0 got %b want 0", PSEL); else n_pass++;
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE} !== 2'b10) $display("FAIL sw_setup got %b want 10", {PSEL, PENABLE});
    else n_pass++;
    n_checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== {1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'd2})
      $display("FAIL sw_fields got %h want %h", {PWRITE, PADDR, PWDATA, PSTRB, PPROT},
               {1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'd2});
    else n_pass++;
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE} !== 2'b11) $display("FAIL sw_access got %b want 11", {PSEL, PENABLE});
    else n_pass++;
    @(negedge PCLK);
    n_checks++;
    if ({RSP_VALID, RSP_RDATA, RSP_SLVERR, RSP_TIMEOUT} !== {1'b1, 32'h0, 2'b00})
      $display("FAIL sw_rsp got %h want %h", {RSP_VALID, RSP_RDATA, RSP_SLVERR, RSP_TIMEOUT},
               {1'b1, 32'h0, 2'b00});
    else n_pass++;
    n_checks++;
    if (PSEL !== 1'b0) $display("FAIL sw_idle got %b want 0", PSEL); else n_pass++;
    repeat (3) @(negedge PCLK);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL sw_rsp_count got %0d want 1", got_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok, ok_all, found;
    int psel_hi = 0, pen_hi = 0, strb_nz = 0, n = 0;
    got_q.delete(); exp_q.delete();
    ok_all = 1'b1; found = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(model_rsp(1'b0, 32'((i + 1) * 16), 1'b0));
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          push_cmd(1'b0, 32'((i + 1) * 16), 32'hDEAD0000 + 32'(i), 4'hF, 3'(i), ok);
          ok_all &= ok;
        end
      end
      begin
        while (!PSEL && n < 20) begin @(negedge PCLK); n++; end
        found = PSEL;
        for (int i = 0; i < 8; i++) begin
          if (PSEL) psel_hi++;
          if (PSEL && PENABLE) pen_hi++;
          if (PSEL && PSTRB != 4'h0) strb_nz++;
          @(negedge PCLK);
        end
      end
    join
    n_checks++;
    if (!(ok_all && found)) $display("FAIL b2b_start got push_ok=%b psel_seen=%b want 1/1", ok_all, found);
    else n_pass++;
    n_checks++;
    if (psel_hi !== 8) $display("FAIL b2b_psel_cont got %0d want 8", psel_hi); else n_pass++;
    n_checks++;
    if (pen_hi !== 4) $display("FAIL b2b_access_cycles got %0d want 4", pen_hi); else n_pass++;
    n_checks++;
    if (strb_nz !== 0) $display("FAIL b2b_read_strb got %0d nonzero want 0", strb_nz); else n_pass++;
    n_checks++;
    if (PSEL !== 1'b0) $display("FAIL b2b_end_idle got %b want 0", PSEL); else n_pass++;
    wait_rsp(4, 50, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_rsp_wait got %0d want 4", got_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL b2b_rsp%0d got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wait_err;
    bit ok;
    int n = 0, acc = 0;
    rsp_t want;
    got_q.delete();
    cfg_wait = 3; cfg_err = 1'b1;
    want = model_rsp(1'b0, 32'h80, 1'b1);
    push_cmd(1'b0, 32'h80, 32'h0, 4'h0, 3'd1, ok);
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    while (PSEL && PENABLE && acc < 100) begin acc++; @(negedge PCLK); end
    n_checks++;
    if (acc !== 4) $display("FAIL we_access_len got %0d want 4", acc); else n_pass++;
    wait_rsp(1, 20, ok);
    n_checks++;
    if (!ok || got_q[0] !== want) $display("FAIL we_rsp got %h want %h", ok ? got_q[0] : '0, want);
    else n_pass++;
    cfg_wait = 0; cfg_err = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    int n = 0, acc = 0;
    rsp_t want0, want1;
    got_q.delete();
    want0 = '{rdata: 32'h0, slverr: 1'b1, to: 1'b1};
    want1 = model_rsp(1'b1, 32'h200, 1'b0);
    cfg_stuck = 1'b1;
    push_cmd(1'b0, 32'h100, 32'h0, 4'h0, 3'd0, ok);
    push_cmd(1'b1, 32'h200, 32'h12345678, 4'h3, 3'd5, ok);
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    while (PSEL && PENABLE && acc < 100) begin acc++; @(negedge PCLK); end
    // TO wait cycles, then the cycle in which the compare fires
    n_checks++;
    if (acc !== TO + 1) $display("FAIL to_access_len got %0d want %0d", acc, TO + 1); else n_pass++;
    n_checks++;
    if (PSEL !== 1'b0) $display("FAIL to_psel_drop got %b want 0", PSEL); else n_pass++;
    cfg_stuck = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT} !== {3'b101, 32'h200, 4'h3, 3'd5})
      $display("FAIL to_next_launch got %h want %h", {PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT},
               {3'b101, 32'h200, 4'h3, 3'd5});
    else n_pass++;
    wait_rsp(2, 30, ok);
    n_checks++;
    if (!ok || got_q[0] !== want0) $display("FAIL to_rsp0 got %h want %h", ok ? got_q[0] : '0, want0);
    else n_pass++;
    n_checks++;
    if (!ok || got_q[1] !== want1) $display("FAIL to_rsp1 got %h want %h", ok ? got_q[1] : '0, want1);
    else n_pass++;
  endtask

  task automatic test_timeout_boundary;
    bit ok;
    int n = 0, acc = 0;
    rsp_t want;
    got_q.delete();
    cfg_wait = TO;
    want = model_rsp(1'b0, 32'h300, 1'b0);
    push_cmd(1'b0, 32'h300, 32'h0, 4'h0, 3'd0, ok);
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    while (PSEL && PENABLE && acc < 100) begin acc++; @(negedge PCLK); end
    n_checks++;
    if (acc !== TO + 1) $display("FAIL tb_access_len got %0d want %0d", acc, TO + 1); else n_pass++;
    wait_rsp(1, 20, ok);
    n_checks++;
    if (!ok || got_q[0] !== want) $display("FAIL tb_pready_wins got %h want %h", ok ? got_q[0] : '0, want);
    else n_pass++;
    cfg_wait = 0;
  endtask

  task automatic test_rsp_backpressure;
    bit ok, ok_all;
    int c0;
    got_q.delete(); exp_q.delete();
    ok_all = 1'b1;
    RSP_READY = 1'b0;
    c0 = n_complete;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model_rsp(1'b0, 32'h400 + 32'(i * 16), 1'b0));
      push_cmd(1'b0, 32'h400 + 32'(i * 16), 32'h0, 4'h0, 3'd0, ok);
      ok_all &= ok;
    end
    repeat (20) @(negedge PCLK);
    n_checks++;
    if (!ok_all || (n_complete - c0) !== 2)
      $display("FAIL bp_completions got %0d (push_ok=%b) want 2", n_complete - c0, ok_all);
    else n_pass++;
    n_checks++;
    if ({PSEL, RSP_VALID} !== 2'b01) $display("FAIL bp_stalled got %b want 01", {PSEL, RSP_VALID});
    else n_pass++;
    n_checks++;
    if ({CMD_LEVEL, CMD_READY} !== {3'd4, 1'b0})
      $display("FAIL bp_full got level=%0d ready=%b want 4/0", CMD_LEVEL, CMD_READY);
    else n_pass++;
    RSP_READY = 1'b1;
    wait_rsp(6, 100, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_resume got %0d want 6", got_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL bp_rsp%0d got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random;
    bit ok, w;
    logic [31:0] a;
    got_q.delete(); exp_q.delete();
    stab_viol = 0;
    cfg_random = 1'b1; rand_rsp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom & 32'h0000_0FFC;
      exp_q.push_back(model_rsp(w, a, a[2]));
      push_cmd(w, a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), ok);
      if (!ok) exp_q.pop_back();
    end
    wait_rsp(exp_q.size(), 2000, ok);
    rand_rsp = 1'b0;
    @(posedge PCLK); #1 RSP_READY = 1'b1;
    cfg_random = 1'b0;
    n_checks++;
    if (!ok || exp_q.size() != 40) $display("FAIL rnd_count got %0d want 40", got_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 40; i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rnd_rsp%0d got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (stab_viol !== 0) $display("FAIL rnd_stability got %0d changes want 0", stab_viol); else n_pass++;
  endtask

  task automatic test_reset_mid_access;
    bit ok;
    int n = 0, c0;
    got_q.delete();
    RSP_READY = 1'b1; cfg_stuck = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h500 + 32'(i * 16), 32'h0, 4'h0, 3'd0, ok);
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    repeat (2) @(negedge PCLK);
    n_checks++;
    if ({PSEL, PENABLE, CMD_LEVEL} !== {2'b11, 3'd3})
      $display("FAIL rm_pre got %b/%0d want 11/3", {PSEL, PENABLE}, CMD_LEVEL);
    else n_pass++;
    PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    n_checks++;
    if ({PSEL, RSP_VALID, CMD_LEVEL} !== 5'b0)
      $display("FAIL rm_post got psel=%b rsp_valid=%b level=%0d want 0/0/0", PSEL, RSP_VALID, CMD_LEVEL);
    else n_pass++;
    cfg_stuck = 1'b0;
    c0 = n_complete;
    repeat (30) @(negedge PCLK);
    n_checks++;
    if (got_q.size() !== 0 || n_complete !== c0)
      $display("FAIL rm_no_rsp got rsp=%0d xfers=%0d want 0/0", got_q.size(), n_complete - c0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_err();
    test_timeout();
    test_timeout_boundary();
    test_rsp_backpressure();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
